// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
//   DFF_PIPE_WIDTH / DFF_PIPE_DEPTH : default data width and stage count
//   occ_w(depth)                    : bit width needed to count 0..depth
package dff_pkg;
    localparam int DFF_PIPE_WIDTH = 16;
    localparam int DFF_PIPE_DEPTH = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data register.
//   clk, rst_n : clock, synchronous active-low reset (clears v and d)
//   i_clr      : drop the held word (v <= 0), wins over i_load
//   i_load     : take i_v / i_d on this edge
//   o_v, o_d   : held valid bit and data
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_v,
    output logic [WIDTH-1:0] o_d
);
    logic             r_v;
    logic [WIDTH-1:0] r_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else begin
            if (i_clr)
                r_v <= 1'b0;
            else if (i_load)
                r_v <= i_v;
            // data is don't-care once the valid bit is cleared, so skip the load
            if (i_load && !i_clr)
                r_d <= i_d;
        end
    end

    assign o_v = r_v;
    assign o_d = r_d;
endmodule

// File: rtl/dff_pipe.sv
// Handshaked register pipeline of DEPTH stages with bubble collapse and flush.
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid, in_ready, in_data   : upstream handshake
//   out_valid, out_ready, out_data: downstream handshake (last stage)
//   flush                         : drop every held word on the next edge
//   occupancy                     : registered count of valid stages
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH,
    parameter int DEPTH = DFF_PIPE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     flush,
    output logic [occ_w(DEPTH)-1:0]  occupancy
);
    localparam int OW = occ_w(DEPTH);

    logic [DEPTH-1:0]            w_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_d;
    logic [DEPTH-1:0]            w_adv;
    logic [DEPTH-1:0]            w_src_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_src_d;
    logic [DEPTH-1:0]            w_v_nxt;
    logic [OW-1:0]               w_occ_nxt;
    logic [OW-1:0]               r_occ;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            // A stage advances when downstream drains or any later stage
            // holds a bubble; written flat to avoid a combinational chain.
            if (g == DEPTH - 1) begin : g_last
                assign w_adv[g] = out_ready | ~w_v[g];
            end else begin : g_mid
                assign w_adv[g] = out_ready | ~(&w_v[DEPTH-1:g+1]);
            end

            if (g == 0) begin : g_head
                assign w_src_v[g] = in_valid;
                assign w_src_d[g] = in_data;
            end else begin : g_body
                assign w_src_v[g] = w_v[g-1];
                assign w_src_d[g] = w_d[g-1];
            end

            assign w_v_nxt[g] = flush ? 1'b0 : (w_adv[g] ? w_src_v[g] : w_v[g]);

            dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_clr  (flush),
                .i_load (w_adv[g]),
                .i_v    (w_src_v[g]),
                .i_d    (w_src_d[g]),
                .o_v    (w_v[g]),
                .o_d    (w_d[g])
            );
        end
    endgenerate

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            w_occ_nxt = w_occ_nxt + OW'(w_v_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_occ <= '0;
        else
            r_occ <= w_occ_nxt;
    end

    // rst_n gate keeps upstream from seeing a handshake while in reset
    assign in_ready  = rst_n & ~flush & w_adv[0];
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign occupancy = r_occ;
endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;
    logic        clk;
    logic        rst_n;
    // DEPTH=4 instance
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [15:0] in_data, out_data;
    logic [2:0]  occupancy;
    // DEPTH=1 instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, flush1;
    logic [15:0] in_data1, out_data1;
    logic [0:0]  occupancy1;

    int n_checks = 0;
    int n_fail   = 0;

    dff_pipe #(.WIDTH(16), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .occupancy(occupancy)
    );

    dff_pipe #(.WIDTH(16), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .flush(flush1), .occupancy(occupancy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
        in_valid1 = 0; in_data1 = '0; out_ready1 = 0; flush1 = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1; in_data = 16'h1234; out_ready = 1; flush = 0;
        in_valid1 = 1; in_data1 = 16'h4321; out_ready1 = 1; flush1 = 0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        n_checks++; if (out_valid1 !== 1'b0 || occupancy1 !== 1'b0 || in_ready1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_depth1: got v=%b occ=%b rdy=%b want 0/0/0", out_valid1, occupancy1, in_ready1); end
        rst_n = 1'b1; in_valid = 0; out_ready = 0; in_valid1 = 0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_stream;
        apply_reset();
        out_ready = 1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_data  = 16'(c + 1);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); end
            n_checks++; if (out_valid !== (c >= 4 && c <= 11)) begin
                n_fail++; $display("FAIL stream_out_valid c=%0d: got %b want %b", c, out_valid, (c >= 4 && c <= 11)); end
            if (c >= 4 && c <= 11) begin
                n_checks++; if (out_data !== 16'(c - 3)) begin
                    n_fail++; $display("FAIL stream_out_data c=%0d: got %h want %h", c, out_data, 16'(c - 3)); end
            end
            tick();
        end
        in_valid = 0;
    endtask

    task automatic test_fill;
        int idx;
        int exp;
        apply_reset();
        out_ready = 0;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1; in_data = 16'(idx);
            #1;
            n_checks++; if (in_ready !== (c < 4)) begin n_fail++; $display("FAIL fill_in_ready c=%0d: got %b want %b", c, in_ready, (c < 4)); end
            if (in_ready) idx++;
            tick();
        end
        in_valid = 1; in_data = 16'(idx);
        #1;
        n_checks++; if (idx !== 5) begin n_fail++; $display("FAIL fill_accepted: got %0d want 4", idx - 1); end
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occupancy: got %0d want 4", occupancy); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
            n_fail++; $display("FAIL fill_head: got v=%b d=%h want 1/0001", out_valid, out_data); end
        out_ready = 1;
        exp = 1;
        for (int c = 0; c < 30 && exp <= 6; c++) begin
            in_valid = (idx <= 6); in_data = 16'(idx);
            #1;
            if (out_valid) begin
                n_checks++; if (out_data !== 16'(exp)) begin n_fail++; $display("FAIL fill_drain_order: got %h want %h", out_data, 16'(exp)); end
                exp++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        n_checks++; if (exp !== 7) begin n_fail++; $display("FAIL fill_drain_count: got %0d want 6", exp - 1); end
        in_valid = 0; out_ready = 0;
    endtask

    task automatic test_pass_through;
        apply_reset();
        out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1; in_data = 16'(c + 1);
            tick();
        end
        in_valid = 1; in_data = 16'd5; out_ready = 1;
        #1;
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL pass_full_occ: got %0d want 4", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_data !== 16'd1) begin n_fail++; $display("FAIL pass_head: got %h want 0001", out_data); end
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL pass_occ_after: got %0d want 4", occupancy); end
        n_checks++; if (out_data !== 16'd2) begin n_fail++; $display("FAIL pass_next_head: got %h want 0002", out_data); end
        out_ready = 1;
        for (int k = 2; k <= 5; k++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
                n_fail++; $display("FAIL pass_drain: got v=%b d=%h want 1/%h", out_valid, out_data, 16'(k)); end
            tick();
        end
        out_ready = 0;
    endtask

    task automatic test_flush;
        logic seen;
        apply_reset();
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_data = 16'(16'h20 + c);
            tick();
        end
        in_valid = 0;
        #1;
        n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy); end
        flush = 1; in_valid = 1; in_data = 16'h00AA;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        #1;
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        out_ready = 1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_word_leaked: got 1 want 0"); end
        out_ready = 0;
    endtask

    task automatic test_reset_midstream;
        apply_reset();
        out_ready = 1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; in_data = 16'(16'h10 + c);
            tick();
        end
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", out_valid); end
        rst_n = 0; flush = 1; in_valid = 1; in_data = 16'h0055; out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 3'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got v=%b d=%h occ=%0d rdy=%b want 0/0000/0/0", out_valid, out_data, occupancy, in_ready); end
        rst_n = 1; flush = 0; in_valid = 1; in_data = 16'hBEEF;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) in_valid = 0;
            #1;
            n_checks++; if (out_valid !== (c == 4)) begin n_fail++; $display("FAIL rstmid_latency c=%0d: got %b want %b", c, out_valid, (c == 4)); end
            if (c == 4) begin
                n_checks++; if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL rstmid_data: got %h want beef", out_data); end
            end
            tick();
        end
        out_ready = 0;
    endtask

    task automatic test_depth1;
        int idx, exp, acc, del;
        apply_reset();
        in_valid1 = 1;
        idx = 1; exp = 1; acc = 0; del = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready1 = (c % 2 == 0);
            in_data1 = 16'(idx);
            #1;
            n_checks++; if (in_ready1 !== (c % 2 == 0)) begin n_fail++; $display("FAIL d1_in_ready c=%0d: got %b want %b", c, in_ready1, (c % 2 == 0)); end
            if (out_valid1 && out_ready1) begin
                n_checks++; if (out_data1 !== 16'(exp)) begin n_fail++; $display("FAIL d1_order: got %h want %h", out_data1, 16'(exp)); end
                exp++; del++;
            end
            if (in_ready1) begin idx++; acc++; end
            tick();
        end
        n_checks++; if (acc !== 10 || del !== 9) begin n_fail++; $display("FAIL d1_counts: got acc=%0d del=%0d want 10/9", acc, del); end
        in_valid1 = 0; out_ready1 = 1;
        #1;
        if (out_valid1) begin
            n_checks++; if (out_data1 !== 16'(exp)) begin n_fail++; $display("FAIL d1_last: got %h want %h", out_data1, 16'(exp)); end
            del++;
        end
        tick();
        n_checks++; if (del !== acc || out_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL d1_balance: got del=%0d acc=%0d v=%b want equal/0", del, acc, out_valid1); end
        out_ready1 = 0;
    endtask

    initial begin
        rst_n = 0;
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
        in_valid1 = 0; in_data1 = '0; out_ready1 = 0; flush1 = 0;
        test_reset();
        test_stream();
        test_fill();
        test_pass_through();
        test_flush();
        test_reset_midstream();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of register stages, legal range 1..16.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: synchronous and active-low.
REQ-005 Port in_valid, input, 1, SHALL mean that in_data holds a word offered by upstream.
REQ-006 Port in_ready, output, 1, SHALL mean that the block accepts in_data on this edge.
REQ-007 Port in_data, input, WIDTH, SHALL carry the input word.
REQ-008 Port out_valid, output, 1, SHALL mean that out_data holds a word for downstream.
REQ-009 Port out_ready, input, 1, SHALL mean that downstream takes out_data on this edge.
REQ-010 Port out_data, output, WIDTH, SHALL be the registered output of the last stage.
REQ-011 Port flush, input, 1, SHALL discard all held words on the next edge.
REQ-012 Port occupancy, output, $clog2(DEPTH+1), SHALL give the count of valid stages.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and a data register d[i]; stage 0 is the input side and stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage DEPTH-1 SHALL advance when out_ready=1 or v[DEPTH-1]=0; stage i<DEPTH-1 SHALL advance when v[i+1]=0 or stage i+1 advances (bubble collapse).
REQ-015 On an advancing edge, stage i SHALL load the contents of stage i-1; stage 0 SHALL load in_valid/in_data.
REQ-016 A stage that does not advance SHALL hold its v and d unchanged.
REQ-017 in_ready SHALL equal (stage 0 advances) AND NOT flush; it is a combinational function of the valid bits, out_ready and flush.
REQ-018 A word SHALL be accepted only on an edge with in_valid=1 and in_ready=1; a word SHALL be delivered only on an edge with out_valid=1 and out_ready=1.
REQ-019 With out_ready held at 1 and no flush, a word accepted at edge t SHALL appear with out_valid=1 after edge t+DEPTH-1, giving a latency of DEPTH cycles; sustained throughput SHALL be one word per cycle.
REQ-020 Under backpressure (out_ready=0), upstream bubbles SHALL collapse so that at most DEPTH words are held; in_ready SHALL drop only when all DEPTH stages are valid and stage DEPTH-1 does not advance.
REQ-021 When full, an edge with out_ready=1 and in_valid=1 SHALL deliver one word and accept one word in the same edge, and occupancy SHALL stay at DEPTH.
REQ-022 Word order SHALL be preserved and no word SHALL be duplicated or dropped, except on flush.
REQ-023 flush=1 SHALL clear every v[i] to 0 on the next edge, regardless of out_ready. On that edge no word SHALL be accepted, and a word presented with out_ready=1 SHALL still count as delivered.
REQ-024 occupancy SHALL be registered and equal the popcount of v[] after each edge.
REQ-025 When DEPTH=1, the block SHALL behave as a single handshaked register with in_ready = (NOT v[0] OR out_ready) AND NOT flush.

Reset
REQ-026 When rst_n=0 at a rising edge, every v[i] SHALL be set to 0, every d[i] to 0 and occupancy to 0; out_valid=0 and out_data=0 SHALL follow.
REQ-027 Reset SHALL take priority over flush and over any handshake on the same edge; words in flight at reset SHALL be lost.
REQ-028 While rst_n=0, in_ready SHALL be 0.

Structure
REQ-029 A shared package dff_pkg SHALL hold the default constants DFF_PIPE_WIDTH=16 and DFF_PIPE_DEPTH=4 and the occupancy-width helper function.
REQ-030 Each stage SHALL be an instance of the sub-module dff_pipe_stage (valid plus WIDTH-bit data register with load enable, sync active-low reset and clear), generated DEPTH times.

Verification
REQ-031 Streaming case, WIDTH=16, DEPTH=4, out_ready=1: send 0x0001..0x0008 back-to-back -> same sequence appears from the 4th cycle onward, one word per cycle, in_ready always 1.
REQ-032 Fill case: out_ready=0, offer 6 words -> 4 accepted, in_ready=0 after the 4th, occupancy=4; raise out_ready -> words 1..6 delivered in order.
REQ-033 Full pass-through case: while full, one edge with in_valid=1 and out_ready=1 -> word 1 delivered, word 5 accepted, occupancy stays 4.
REQ-034 Flush case: occupancy=3, assert flush with in_valid=1 -> next edge occupancy=0, out_valid=0, input word not accepted (in_ready=0 during flush).
REQ-035 Reset case: rst_n=0 mid-stream with flush=1 and full handshakes -> after the edge all outputs are 0 and in_ready=0; after release, a new word 0xBEEF emerges with latency 4.
REQ-036 DEPTH=1 case: alternate out_ready 1/0 with continuous input -> accepted and delivered counts match, and each word is delivered exactly once in order.
